// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
//   Shared AES-128 definitions for the key-schedule slice:
//     - NR / NK round and key-word counts
//     - ks_state_e : key-schedule FSM state encoding (IDLE, EXPAND, DONE)
//     - sbox()     : forward AES S-box lookup
//     - xtime()    : multiply-by-x in GF(2^8) modulo x^8+x^4+x^3+x+1
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int NR = 10;   // rounds for AES-128
    localparam int NK = 4;    // 32-bit words per cipher key

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_e;

    // Forward S-box, entry 0x00 in the top byte, entry 0xff in the bottom byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[8 * (255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_ks_g.sv
// -----------------------------------------------------------------------------
// aes_ks_g
//   The key-schedule "g" function for one AES-128 round:
//     g = SubWord(RotWord(word_in)) ^ {rcon, 24'h0}
//   Byte 0 of a word is in bits [31:24].
// Ports
//   word_in  in   32  last word (p3) of the previous round key
//   rcon     in    8  round constant for the round being computed
//   g_out    out  32  transformed word, XORed into w0 by the caller
// -----------------------------------------------------------------------------
module aes_ks_g
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [7:0]  rcon,
    output logic [31:0] g_out
);

    logic [31:0] rot_word;
    logic [31:0] sub_word;

    // RotWord: {a0,a1,a2,a3} -> {a1,a2,a3,a0}
    assign rot_word = {word_in[23:0], word_in[31:24]};

    assign sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                       sbox(rot_word[15:8]),  sbox(rot_word[7:0])};

    assign g_out = sub_word ^ {rcon, 24'h0};

endmodule

// File: rtl/aes_key_sched_seq.sv
// -----------------------------------------------------------------------------
// aes_key_sched_seq
//   Iterative AES-128 key expansion: one round key per clock into an 11-slot
//   register file. A key accepted at edge N yields keys_valid/done after N+10.
//   Optional build macro: AES_KS_FLAT_BUS_EN adds the flat 'words' output.
// Ports
//   clk        in     1  clock, rising edge
//   rst_n      in     1  asynchronous active-low reset
//   key_in     in   128  cipher key, byte 0 in [127:120]
//   key_valid  in     1  key_in valid (transfer on key_valid & key_ready)
//   key_ready  out    1  a key may be accepted this cycle (IDLE or DONE)
//   keys_valid out    1  all 11 round keys are present and stable
//   done       out    1  single-cycle pulse on expansion completion
//   rk_idx     in     4  round-key read index 0..10 (11..15 read as zero)
//   rk_data    out  128  registered round key slot[rk_idx]
//   words      out 1408  (AES_KS_FLAT_BUS_EN only) round 0 in [1407:1280]
//                        down to round 10 in [127:0]
// -----------------------------------------------------------------------------
module aes_key_sched_seq
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [127:0]  key_in,
    input  logic          key_valid,
    output logic          key_ready,
    output logic          keys_valid,
    output logic          done,
    input  logic [3:0]    rk_idx,
    output logic [127:0]  rk_data
`ifdef AES_KS_FLAT_BUS_EN
    ,
    output logic [1407:0] words
`endif
);

    ks_state_e    state, next_state;
    logic [127:0] slots [0:NR];
    logic [3:0]   rnd;
    logic [7:0]   rcon;

    logic         accept;
    logic         expanding;
    logic         last_round;
    logic [127:0] prev_rk;
    logic [127:0] next_rk;
    logic [31:0]  g_word;
    logic [31:0]  w0, w1, w2, w3;

    assign accept     = key_valid && key_ready;
    assign expanding  = (state == EXPAND);
    assign last_round = expanding && (rnd == 4'(NR));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register in an edge-triggered block is updated with <=
        // so all state advances together from the values sampled at the edge.
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        // NOTE: defaults come first so no path leaves an output unassigned,
        // which would otherwise infer a latch.
        next_state = state;
        key_ready  = 1'b1;
        unique case (state)
            IDLE:    if (accept) next_state = EXPAND;
            EXPAND: begin
                key_ready = 1'b0;
                if (rnd == 4'(NR)) next_state = DONE;
            end
            DONE:    if (accept) next_state = EXPAND;
            default: next_state = IDLE;
        endcase
    end

    // ---------------- round datapath ----------------
    // Select slot r-1 without ever indexing the array out of range.
    always_comb begin
        prev_rk = '0;
        for (int i = 0; i < NR; i++) begin
            if (rnd == 4'(i + 1)) prev_rk = slots[i];
        end
    end

    aes_ks_g u_g (
        .word_in (prev_rk[31:0]),
        .rcon    (rcon),
        .g_out   (g_word)
    );

    assign w0      = prev_rk[127:96] ^ g_word;
    assign w1      = prev_rk[95:64]  ^ w0;
    assign w2      = prev_rk[63:32]  ^ w1;
    assign w3      = prev_rk[31:0]   ^ w2;
    assign next_rk = {w0, w1, w2, w3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the slot file is reset explicitly because reset must read
            // back as all-zero round keys, not as whatever the flops power up to.
            for (int i = 0; i <= NR; i++) slots[i] <= '0;
            rnd        <= '0;
            rcon       <= 8'h01;
            keys_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= last_round;
            if (accept) begin
                slots[0]   <= key_in;
                rnd        <= 4'd1;
                rcon       <= 8'h01;
                keys_valid <= 1'b0;
            end else if (expanding) begin
                for (int i = 1; i <= NR; i++) begin
                    if (rnd == 4'(i)) slots[i] <= next_rk;
                end
                rcon <= xtime(rcon);
                if (last_round) keys_valid <= 1'b1;
                else            rnd        <= rnd + 4'd1;
            end
        end
    end

    // ---------------- read port ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  rk_data <= '0;
        else if (rk_idx <= 4'(NR))   rk_data <= slots[rk_idx];
        else                         rk_data <= '0;
    end

`ifdef AES_KS_FLAT_BUS_EN
    // Continuous view of the whole schedule for the iterative cipher.
    for (genvar i = 0; i <= NR; i++) begin : g_flat
        assign words[1407 - 128 * i -: 128] = slots[i];
    end
`else
    // Without the flat bus the schedule is reachable only via rk_idx/rk_data.
`endif

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// -----------------------------------------------------------------------------
// tb_aes_key_sched_seq
//   Self-checking bench for aes_key_sched_seq. Expected round keys are the
//   published AES-128 expansions of 000102..0f and 2b7e15..4f3c. Read requests
//   push the expected value into a queue; the registered rk_data is popped and
//   compared one cycle later. Define AES_KS_FLAT_BUS_EN to cover the words bus.
// -----------------------------------------------------------------------------
module tb_aes_key_sched_seq;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [127:0]  key_in;
    logic          key_valid;
    logic          key_ready;
    logic          keys_valid;
    logic          done;
    logic [3:0]    rk_idx;
    logic [127:0]  rk_data;
`ifdef AES_KS_FLAT_BUS_EN
    logic [1407:0] words;
`endif

    aes_key_sched_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .keys_valid (keys_valid),
        .done       (done),
        .rk_idx     (rk_idx),
        .rk_data    (rk_data)
`ifdef AES_KS_FLAT_BUS_EN
        ,
        .words      (words)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] ks_a [0:10] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    logic [127:0] ks_b [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] exp_q [$];

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // All driving and sampling happens 1 time unit after a rising edge.
    task automatic load_key(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    // Cycles after the accept edge until done rises; -1 if it never does.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Scoreboarded read: expectation queued when the index is driven,
    // compared when the registered data appears one edge later.
    task automatic read_rk(input int idx, input logic [127:0] exp);
        logic [127:0] want;
        rk_idx = 4'(idx);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        want = exp_q.pop_front();
        check($sformatf("rk%0d", idx), rk_data, want);
    endtask

    task automatic read_schedule(input bit use_b);
        for (int i = 0; i <= 10; i++) read_rk(i, use_b ? ks_b[i] : ks_a[i]);
        read_rk(11, 128'h0);
        read_rk(15, 128'h0);
    endtask

    initial begin
        int cyc;
        int done_cnt;

        rst_n     = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        rk_idx    = '0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_key_ready",  128'(key_ready),  128'd1);
        check("rst_keys_valid", 128'(keys_valid), 128'd0);
        check("rst_done",       128'(done),       128'd0);
        check("rst_rk_data",    rk_data,          128'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- key A: latency, handshake and full schedule ----
        load_key(KEY_A);
        check("a_ready_in_expand", 128'(key_ready),  128'd0);
        check("a_kv_in_expand",    128'(keys_valid), 128'd0);
        wait_done(cyc);
        check("a_latency",         128'(cyc),        128'd10);
        check("a_kv_at_done",      128'(keys_valid), 128'd1);
        @(posedge clk); #1;
        check("a_done_one_cycle",  128'(done),       128'd0);
        check("a_ready_in_done",   128'(key_ready),  128'd1);
        read_schedule(1'b0);
`ifdef AES_KS_FLAT_BUS_EN
        check("flat_round0",  words[1407:1280], KEY_A);
        check("flat_round10", words[127:0],     ks_a[10]);
`endif

        // ---- reload from DONE: key B replaces A ----
        load_key(KEY_B);
        check("reload_kv_drop", 128'(keys_valid), 128'd0);
        wait_done(cyc);
        check("reload_latency", 128'(cyc),        128'd10);
        read_schedule(1'b1);
        read_rk(12, 128'h0);

        // ---- key_valid held through EXPAND with another key ----
        key_in    = KEY_A;
        key_valid = 1'b1;
        @(posedge clk); #1;     // accept A
        key_in   = KEY_B;       // must be ignored while expanding
        done_cnt = 0;
        cyc      = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 3) check("hold_ready_low", 128'(key_ready), 128'd0);
            if (done) begin
                done_cnt++;
                if (cyc < 0) cyc = i;
            end
        end
        key_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("hold_done_count", 128'(done_cnt), 128'd1);
        check("hold_latency",    128'(cyc),      128'd10);
        read_rk(1,  ks_a[1]);
        read_rk(10, ks_a[10]);

        // ---- reset in the middle of an expansion ----
        load_key(KEY_B);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready",   128'(key_ready),  128'd1);
        check("mid_rst_kv",      128'(keys_valid), 128'd0);
        check("mid_rst_rk_data", rk_data,          128'h0);
        done_cnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || keys_valid) done_cnt++;
        end
        check("mid_rst_no_done", 128'(done_cnt), 128'd0);
        read_rk(0,  128'h0);
        read_rk(10, 128'h0);

        load_key(KEY_A);
        wait_done(cyc);
        check("post_rst_latency", 128'(cyc), 128'd10);
        read_rk(10, ks_a[10]);
        read_rk(4,  ks_a[4]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
